puc_core: RTL and testbench

- Parametrised successor of the single-accumulator teaching CPU.
- Two-stage fetch/execute core with an N-entry register file, flags, conditional branches, a halt state, and a synchronous external instruction-memory port.
- Top-level processing block; instruction ROM/RAM sits outside and is driven by imemAddr.

---
 rtl/puc_pkg.sv | 33 +++
 rtl/puc_alu_param.sv | 31 +++
 rtl/puc_core.sv | 204 ++++++++++++++++++++
 tb/tb_puc_core.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puc_pkg.sv
// puc_pkg: opcode, ALU-op types and instruction field positions
// shared by puc_core and puc_alu_param.
package puc_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_LOADI = 4'd1,
    OP_ADD   = 4'd2,
    OP_SUB   = 4'd3,
    OP_MOVE  = 4'd4,
    OP_MOVEB = 4'd5,
    OP_JUMP  = 4'd6,
    OP_JZ    = 4'd7,
    OP_JNZ   = 4'd8,
    OP_RESET = 4'd9,
    OP_HALT  = 4'd10,
    OP_CALL  = 4'd11,
    OP_RET   = 4'd12
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_SUB  = 2'd2
  } alu_op_e;

  // Field MSBs, counted down from the top of the instruction word.
  localparam int OPC_MSB = 1;
  localparam int REG_MSB = 5;
  localparam int IMM_MSB = 9;
  localparam int OPC_W   = 4;

endpackage

// File: rtl/puc_alu_param.sv
// puc_alu_param: combinational add/sub/pass with carry (borrow on
// subtract) and zero outputs.
module puc_alu_param
  import puc_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  alu_op_e               op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  carry,
  output logic                  zero
);

  logic [DATA_WIDTH:0] ext;

  always_comb begin
    ext = {1'b0, b};
    case (op)
      ALU_ADD: ext = {1'b0, a} + {1'b0, b};
      ALU_SUB: ext = {1'b0, a} - {1'b0, b};
      default: ext = {1'b0, b};
    endcase
  end

  assign y     = ext[DATA_WIDTH-1:0];
  assign carry = ext[DATA_WIDTH];
  assign zero  = (y == '0);

endmodule

// File: rtl/puc_core.sv
// puc_core: two-stage fetch/execute accumulator core with register file.
// Define PUC_CALL_STACK_EN to enable CALL/RET and the return stack.
module puc_core
  import puc_pkg::*;
#(
  parameter int DATA_WIDTH        = 8,
  parameter int PC_WIDTH          = 8,
  parameter int NUM_REGS          = 4,
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int STACK_DEPTH       = 4
) (
  input  logic                         clock,
  input  logic                         resetN,
  output logic [PC_WIDTH-1:0]          imemAddr,
  input  logic [INSTRUCTION_WIDTH-1:0] imemData,
  output logic                         isReset,
  output logic                         halted,
  output logic [DATA_WIDTH-1:0]        accumulator,
  output logic [DATA_WIDTH-1:0]        register1,
  output logic [DATA_WIDTH-1:0]        aluResult,
  output logic                         zeroFlag,
  output logic                         carryFlag,
  output logic                         stackError
);

  localparam int RW = $clog2(NUM_REGS);
  localparam int IW = INSTRUCTION_WIDTH;

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HALT = 1'b1;

  logic [0:0]            state;
  logic [PC_WIDTH-1:0]   pc;
  logic                  exec_valid;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  zf;
  logic                  cf;

  logic [OPC_W-1:0]      opc;
  logic [RW-1:0]         rsel;
  logic [IW-IMM_MSB:0]   imm;
  logic [DATA_WIDTH-1:0] imm_d;
  logic [PC_WIDTH-1:0]   imm_p;
  logic [DATA_WIDTH-1:0] rdata;

  assign opc   = imemData[IW-OPC_MSB -: OPC_W];
  assign rsel  = imemData[IW-REG_MSB-3 +: RW];
  assign imm   = imemData[IW-IMM_MSB:0];
  assign imm_d = imm[DATA_WIDTH-1:0];
  assign imm_p = imm[PC_WIDTH-1:0];
  assign rdata = regs[rsel];

  logic ex;
  logic is_loadi, is_add, is_sub, is_move, is_moveb;
  logic is_reset, is_halt, jump_taken;

  assign ex         = exec_valid && (state == S_RUN);
  assign is_loadi   = ex && (opc == OP_LOADI);
  assign is_add     = ex && (opc == OP_ADD);
  assign is_sub     = ex && (opc == OP_SUB);
  assign is_move    = ex && (opc == OP_MOVE);
  assign is_moveb   = ex && (opc == OP_MOVEB);
  assign is_reset   = ex && (opc == OP_RESET);
  assign is_halt    = ex && (opc == OP_HALT);
  // JZ/JNZ see the flag as left by the previous instruction.
  assign jump_taken = ex && ((opc == OP_JUMP)
                    || ((opc == OP_JZ) && zf)
                    || ((opc == OP_JNZ) && !zf));

  alu_op_e               alu_op;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [DATA_WIDTH-1:0] alu_y;
  logic                  alu_c;
  logic                  alu_z;

  always_comb begin
    alu_op = ALU_PASS;
    alu_b  = rdata;
    if (opc == OP_ADD) alu_op = ALU_ADD;
    if (opc == OP_SUB) alu_op = ALU_SUB;
    if (opc == OP_LOADI) alu_b = imm_d;
  end

  puc_alu_param #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .op   (alu_op),
    .a    (acc),
    .b    (alu_b),
    .y    (alu_y),
    .carry(alu_c),
    .zero (alu_z)
  );

`ifdef PUC_CALL_STACK_EN
  localparam int SPW = $clog2(STACK_DEPTH + 1);

  logic [PC_WIDTH-1:0] stack [2**SPW];
  logic [SPW-1:0]      sp;
  logic                stk_err;
  logic                is_call, is_ret;
  logic                stk_full, stk_empty;

  assign is_call   = ex && (opc == OP_CALL);
  assign is_ret    = ex && (opc == OP_RET);
  assign stk_full  = (sp == SPW'(STACK_DEPTH));
  assign stk_empty = (sp == '0);
`endif

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state      <= S_RUN;
      pc         <= '0;
      exec_valid <= 1'b0;
      acc        <= '0;
      zf         <= 1'b0;
      cf         <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
`ifdef PUC_CALL_STACK_EN
      sp      <= '0;
      stk_err <= 1'b0;
`endif
    end else if (state == S_RUN) begin
      pc         <= pc + PC_WIDTH'(1);
      exec_valid <= 1'b1;
      unique case (1'b1)
        is_loadi, is_moveb: begin
          acc <= alu_y;
          zf  <= alu_z;
        end
        is_add, is_sub: begin
          acc <= alu_y;
          zf  <= alu_z;
          cf  <= alu_c;
        end
        is_move: regs[rsel] <= acc;
        jump_taken: begin
          pc         <= imm_p;
          exec_valid <= 1'b0;
        end
        is_reset: begin
          pc         <= '0;
          acc        <= '0;
          zf         <= 1'b0;
          cf         <= 1'b0;
          exec_valid <= 1'b0;
        end
        is_halt: begin
          state      <= S_HALT;
          pc         <= pc;
          exec_valid <= 1'b0;
        end
`ifdef PUC_CALL_STACK_EN
        is_call: begin
          exec_valid <= 1'b0;
          if (stk_full) begin
            state   <= S_HALT;
            stk_err <= 1'b1;
            pc      <= pc;
          end else begin
            stack[sp] <= pc;
            sp        <= sp + SPW'(1);
            pc        <= imm_p;
          end
        end
        is_ret: begin
          exec_valid <= 1'b0;
          if (stk_empty) begin
            state   <= S_HALT;
            stk_err <= 1'b1;
            pc      <= pc;
          end else begin
            sp <= sp - SPW'(1);
            pc <= stack[sp - SPW'(1)];
          end
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef PUC_CALL_STACK_EN
  assign stackError = stk_err;
`else
  logic [31:0] unused_depth;
  assign unused_depth = 32'(STACK_DEPTH);
  assign stackError   = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^imemData;

  assign imemAddr    = pc;
  assign isReset     = is_reset;
  assign halted      = (state == S_HALT);
  assign accumulator = acc;
  assign register1   = regs[1];
  assign aluResult   = alu_y;
  assign zeroFlag    = zf;
  assign carryFlag   = cf;

endmodule

// File: tb/tb_puc_core.sv
// tb_puc_core: directed program checks plus random programs compared
// against an instruction-level interpreter of the puc ISA.
module tb_puc_core;

  localparam int L_NOP = 0, L_LOADI = 1, L_ADD = 2, L_SUB = 3;
  localparam int L_MOVE = 4, L_MOVEB = 5, L_JUMP = 6, L_JZ = 7;
  localparam int L_JNZ = 8, L_RESET = 9, L_HALT = 10;
  localparam int L_CALL = 11, L_RET = 12;

  logic        clock;
  logic        resetN;
  logic [7:0]  imemAddr;
  logic [15:0] imemData;
  logic        isReset;
  logic        halted;
  logic [7:0]  accumulator;
  logic [7:0]  register1;
  logic [7:0]  aluResult;
  logic        zeroFlag;
  logic        carryFlag;
  logic        stackError;

  logic [15:0] rom [256];

  int n_vec = 0;
  int n_bad = 0;

  puc_core #(
    .DATA_WIDTH(8),
    .PC_WIDTH(8),
    .NUM_REGS(4),
    .INSTRUCTION_WIDTH(16),
    .STACK_DEPTH(2)
  ) dut (
    .clock      (clock),
    .resetN     (resetN),
    .imemAddr   (imemAddr),
    .imemData   (imemData),
    .isReset    (isReset),
    .halted     (halted),
    .accumulator(accumulator),
    .register1  (register1),
    .aluResult  (aluResult),
    .zeroFlag   (zeroFlag),
    .carryFlag  (carryFlag),
    .stackError (stackError)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) imemData <= rom[imemAddr];

  function automatic logic [15:0] ins(int op, int r, int imm);
    return {op[3:0], r[3:0], imm[7:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic hold_reset();
    @(negedge clock);
    resetN = 1'b0;
    for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
  endtask

  task automatic release_reset();
    @(negedge clock);
    resetN = 1'b1;
  endtask

  task automatic wait_halt(input int budget);
    for (int k = 0; k < budget && !halted; k++) tick(1);
    check("halt_reached", halted, 1);
  endtask

  // Instruction-level interpreter: runs rom from address 0 up to HALT.
  task automatic iss(output logic [7:0] e_acc, output logic [7:0] e_r1,
                     output logic [7:0] e_pc, output logic e_z,
                     output logic e_c);
    logic [7:0] pc, acc, imm;
    logic [7:0] rf [4];
    logic [8:0] s;
    logic       z, c;
    int         op, r;
    pc = 0; acc = 0; z = 0; c = 0;
    for (int i = 0; i < 4; i++) rf[i] = 0;
    for (int k = 0; k < 2000; k++) begin
      op  = int'(rom[pc][15:12]);
      r   = int'(rom[pc][9:8]);
      imm = rom[pc][7:0];
      pc  = pc + 8'd1;
      if (op == L_HALT) break;
      case (op)
        L_LOADI: begin acc = imm; z = (acc == 0); end
        L_ADD: begin
          s = {1'b0, acc} + {1'b0, rf[r]};
          acc = s[7:0]; c = s[8]; z = (acc == 0);
        end
        L_SUB: begin
          c = (acc < rf[r]); acc = acc - rf[r]; z = (acc == 0);
        end
        L_MOVE:  rf[r] = acc;
        L_MOVEB: begin acc = rf[r]; z = (acc == 0); end
        L_JUMP:  pc = imm;
        L_JZ:    if (z) pc = imm;
        L_JNZ:   if (!z) pc = imm;
        default: ;
      endcase
    end
    e_acc = acc; e_r1 = rf[1]; e_pc = pc; e_z = z; e_c = c;
  endtask

  initial begin
    logic [7:0] e_acc, e_r1, e_pc;
    logic       e_z, e_c;
    int         n, pick, op, imm;
    resetN = 1'b0;

    // Basic program and first-execute latency
    hold_reset();
    rom[0] = ins(L_LOADI, 0, 5);
    rom[1] = ins(L_MOVE, 1, 0);
    rom[2] = ins(L_LOADI, 0, 3);
    rom[3] = ins(L_ADD, 1, 0);
    rom[4] = ins(L_HALT, 0, 0);
    release_reset();
    check("rst_acc", accumulator, 0);
    check("rst_pc", imemAddr, 0);
    check("rst_halted", halted, 0);
    check("rst_zero", zeroFlag, 0);
    check("rst_carry", carryFlag, 0);
    check("rst_stkerr", stackError, 0);
    tick(1);
    check("edge1_acc", accumulator, 0);
    check("edge1_pc", imemAddr, 1);
    tick(1);
    check("edge2_acc", accumulator, 5);
    tick(3);
    check("add_acc", accumulator, 8);
    check("add_r1", register1, 5);
    check("add_zero", zeroFlag, 0);
    check("add_carry", carryFlag, 0);

    // Carry/zero on overflow, JZ taken with squash
    hold_reset();
    rom[0] = ins(L_LOADI, 0, 8'hFF);
    rom[1] = ins(L_MOVE, 2, 0);
    rom[2] = ins(L_LOADI, 0, 1);
    rom[3] = ins(L_ADD, 2, 0);
    rom[4] = ins(L_JZ, 0, 8'h20);
    rom[5] = ins(L_LOADI, 0, 8'h55);
    rom[8'h20] = ins(L_HALT, 0, 0);
    rom[8'h21] = ins(L_LOADI, 0, 8'h77);
    release_reset();
    tick(6);
    check("jz_pc", imemAddr, 8'h20);
    check("ovf_acc", accumulator, 0);
    check("ovf_carry", carryFlag, 1);
    check("ovf_zero", zeroFlag, 1);
    tick(1);
    check("jz_squash_acc", accumulator, 0);
    tick(1);
    check("jz_halted", halted, 1);
    check("jz_halt_pc", imemAddr, 8'h21);

    // pc wrap and SUB borrow
    hold_reset();
    rom[0] = ins(L_LOADI, 0, 2);
    rom[1] = ins(L_MOVE, 3, 0);
    rom[2] = ins(L_LOADI, 0, 1);
    rom[3] = ins(L_JUMP, 0, 8'hFE);
    rom[8'hFE] = ins(L_NOP, 0, 0);
    rom[8'hFF] = ins(L_SUB, 3, 0);
    release_reset();
    tick(7);
    check("wrap_pc", imemAddr, 0);
    tick(1);
    check("sub_acc", accumulator, 8'hFF);
    check("sub_carry", carryFlag, 1);
    check("sub_zero", zeroFlag, 0);
    check("sub_pc", imemAddr, 1);

    // HALT freeze, then asynchronous reset
    hold_reset();
    rom[0] = ins(L_LOADI, 0, 8'h14);
    rom[1] = ins(L_MOVE, 1, 0);
    rom[4] = ins(L_HALT, 0, 0);
    rom[5] = ins(L_LOADI, 0, 8'h99);
    release_reset();
    tick(5);
    check("pre_halt", halted, 0);
    tick(1);
    check("halt_now", halted, 1);
    check("halt_pc", imemAddr, 5);
    tick(20);
    check("halt_acc_stable", accumulator, 8'h14);
    check("halt_pc_stable", imemAddr, 5);
    check("halt_r1", register1, 8'h14);
    @(negedge clock);
    #1 resetN = 1'b0;
    #1;
    check("async_acc", accumulator, 0);
    check("async_r1", register1, 0);
    check("async_halted", halted, 0);
    check("async_pc", imemAddr, 0);

    // Soft RESET opcode
    hold_reset();
    rom[0] = ins(L_LOADI, 0, 9);
    rom[1] = ins(L_MOVE, 1, 0);
    rom[2] = ins(L_LOADI, 0, 7);
    rom[3] = ins(L_RESET, 0, 0);
    rom[4] = ins(L_LOADI, 0, 8'h33);
    release_reset();
    tick(4);
    check("soft_isreset", isReset, 1);
    check("soft_acc_before", accumulator, 7);
    tick(1);
    check("soft_pc", imemAddr, 0);
    check("soft_acc", accumulator, 0);
    check("soft_r1", register1, 9);
    check("soft_isreset_low", isReset, 0);
    tick(1);
    check("soft_squash_acc", accumulator, 0);

`ifdef PUC_CALL_STACK_EN
    // CALL/RET round trip
    hold_reset();
    rom[3] = ins(L_CALL, 0, 8'h10);
    rom[4] = ins(L_MOVE, 1, 0);
    rom[5] = ins(L_HALT, 0, 0);
    rom[8'h10] = ins(L_LOADI, 0, 8'h42);
    rom[8'h11] = ins(L_RET, 0, 0);
    release_reset();
    tick(5);
    check("call_pc", imemAddr, 8'h10);
    tick(3);
    check("ret_pc", imemAddr, 4);
    wait_halt(50);
    check("callret_r1", register1, 8'h42);
    check("callret_stkerr", stackError, 0);
    check("callret_halt_pc", imemAddr, 6);

    // Overflow with depth 2
    hold_reset();
    rom[0] = ins(L_CALL, 0, 8'h10);
    rom[8'h10] = ins(L_CALL, 0, 8'h20);
    rom[8'h20] = ins(L_CALL, 0, 8'h30);
    release_reset();
    wait_halt(50);
    check("ovf_stkerr", stackError, 1);
    check("ovf_pc", imemAddr, 8'h21);

    // Underflow
    hold_reset();
    rom[0] = ins(L_RET, 0, 0);
    release_reset();
    wait_halt(50);
    check("unf_stkerr", stackError, 1);
    check("unf_pc", imemAddr, 1);
`endif

    // Random straight-line/forward-branch programs vs interpreter
    for (int t = 0; t < 8; t++) begin
      hold_reset();
      n = 40;
      for (int a = 0; a < n; a++) begin
        pick = $urandom_range(9, 0);
        op   = (pick == 9) ? 13 + ($urandom % 3) : pick;
        imm  = ($urandom % 4 == 0) ? 0 : int'($urandom % 256);
        if (op == L_JUMP || op == L_JZ || op == L_JNZ)
          imm = $urandom_range(n, a + 1);
        rom[a] = ins(op, $urandom % 16, imm);
      end
      rom[n] = ins(L_HALT, 0, 0);
      iss(e_acc, e_r1, e_pc, e_z, e_c);
      release_reset();
      wait_halt(200);
      check("rnd_acc", accumulator, e_acc);
      check("rnd_r1", register1, e_r1);
      check("rnd_zero", zeroFlag, e_z);
      check("rnd_carry", carryFlag, e_c);
      check("rnd_pc", imemAddr, e_pc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
